// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, read-FSM states and default geometry/timing.
// Used by both the read and write controllers.
package sdram_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_BANK_W = 2;
  localparam int unsigned DEF_ROW_W  = 13;
  localparam int unsigned DEF_COL_W  = 9;
  localparam int unsigned DEF_LEN_W  = 10;
  localparam int unsigned DEF_CL     = 3;
  localparam int unsigned DEF_T_RCD  = 2;
  localparam int unsigned DEF_T_RP   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StTrcd,
    StRd,
    StData,
    StPre,
    StTrp,
    StEnd
  } rd_state_e;

endpackage

// File: rtl/sdram_rd_addr_gen.sv
// Read address walker: holds bank/row/col/remaining, yields the current segment length
// (bounded by the page end) and steps to column 0 of the next row when a segment finishes.
module sdram_rd_addr_gen
  import sdram_pkg::*;
#(
  parameter int unsigned BANK_W = DEF_BANK_W,
  parameter int unsigned ROW_W  = DEF_ROW_W,
  parameter int unsigned COL_W  = DEF_COL_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [BANK_W+ROW_W+COL_W-1:0] addr_i,
  input  logic [LEN_W-1:0]              len_i,
  input  logic                          adv_i,
  output logic [BANK_W-1:0]             bank_o,
  output logic [ROW_W-1:0]              row_o,
  output logic [COL_W-1:0]              col_o,
  output logic [COL_W:0]                seg_o,
  output logic                          more_o
);

  localparam int unsigned PageW = COL_W + 1;
  localparam int unsigned SegW  = (LEN_W > PageW) ? LEN_W : PageW;
  localparam int unsigned BrW   = BANK_W + ROW_W;

  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [LEN_W-1:0]  rem_q;
  logic [PageW-1:0]  space;
  logic [SegW-1:0]   rem_w;
  logic [SegW-1:0]   space_w;

  assign space   = {1'b1, {COL_W{1'b0}}} - {1'b0, col_q};
  assign rem_w   = SegW'(rem_q);
  assign space_w = SegW'(space);
  assign seg_o   = (rem_w < space_w) ? PageW'(rem_q) : space;

  assign bank_o = bank_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign more_o = (rem_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      {bank_q, row_q, col_q} <= addr_i;
      rem_q                  <= len_i;
    end else if (adv_i) begin
      rem_q <= rem_q - LEN_W'(seg_o);
      col_q <= '0;
      // Row overflow carries into the bank, which itself wraps.
      {bank_q, row_q} <= {bank_q, row_q} + BrW'(1);
    end
  end

endmodule

// File: rtl/sdram_burst_read.sv
// SDRAM burst read controller: ACT/READ/BST/PRE sequencing with automatic page-cross splitting
// and a registered per-word data strobe.
module sdram_burst_read
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BANK_W = DEF_BANK_W,
  parameter int unsigned ROW_W  = DEF_ROW_W,
  parameter int unsigned COL_W  = DEF_COL_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned CL     = DEF_CL,
  parameter int unsigned T_RCD  = DEF_T_RCD,
  parameter int unsigned T_RP   = DEF_T_RP
) (
  input  logic                          rd_clk,
  input  logic                          rd_rst,
  input  logic                          init_end,
  input  logic                          rd_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]              rd_bst_len,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          rd_busy,
  output logic                          rd_ack,
  output logic                          rd_end,
  output logic [3:0]                    rd_sdram_cmd,
  output logic [BANK_W-1:0]             rd_sdram_bank,
  output logic [ROW_W-1:0]              rd_sdram_addr,
  output logic [DATA_W-1:0]             rd_sdram_data
);

  localparam int unsigned AddrW = BANK_W + ROW_W + COL_W;
  localparam int unsigned PageW = COL_W + 1;
  localparam int unsigned CntW  = COL_W + 3;

  localparam logic [CntW-1:0]  ClC        = CntW'(CL);
  localparam logic [CntW-1:0]  TrcdC      = CntW'(T_RCD);
  localparam logic [CntW-1:0]  TrpC       = CntW'(T_RP);
  localparam logic [ROW_W-1:0] PreAllAddr = ROW_W'(1024);

  rd_state_e         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        cmd_q;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ack_q;
  logic              end_q;
  logic              busy_q;

  logic              accept;
  logic              seg_done;
  logic [CntW-1:0]   cnt_inc;
  logic [CntW-1:0]   seg_c;
  logic [CntW-1:0]   cl_seg;
  logic [ROW_W-1:0]  col_addr;
  logic [BANK_W-1:0] gen_bank;
  logic [ROW_W-1:0]  gen_row;
  logic [COL_W-1:0]  gen_col;
  logic [PageW-1:0]  seg;
  logic              more;

  assign accept   = (state_q == StIdle) && init_end && rd_en;
  assign cnt_inc  = cnt_q + CntW'(1);
  assign seg_c    = CntW'(seg);
  assign cl_seg   = ClC + seg_c;
  // PRE goes out CL+seg cycles after READ, i.e. together with the last registered word.
  assign seg_done = (state_q == StData) && (cnt_inc == cl_seg);

  always_comb begin
    col_addr     = ROW_W'(gen_col);
    col_addr[10] = 1'b0;
  end

  sdram_rd_addr_gen #(
    .BANK_W(BANK_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk_i (rd_clk),
    .rst_i (rd_rst),
    .load_i(accept),
    .addr_i(rd_addr),
    .len_i (rd_bst_len),
    .adv_i (seg_done),
    .bank_o(gen_bank),
    .row_o (gen_row),
    .col_o (gen_col),
    .seg_o (seg),
    .more_o(more)
  );

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      bank_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      end_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (rd_bst_len == '0) begin
              end_q   <= 1'b1;
              state_q <= StEnd;
            end else begin
              busy_q  <= 1'b1;
              cmd_q   <= CMD_ACT;
              bank_q  <= rd_addr[AddrW-1 -: BANK_W];
              addr_q  <= rd_addr[ROW_W+COL_W-1 -: ROW_W];
              cnt_q   <= '0;
              state_q <= StAct;
            end
          end
        end
        StAct, StTrcd: begin
          if (cnt_inc == TrcdC) begin
            cmd_q   <= CMD_READ;
            bank_q  <= gen_bank;
            addr_q  <= col_addr;
            state_q <= StRd;
          end else begin
            cmd_q   <= CMD_NOP;
            cnt_q   <= cnt_inc;
            state_q <= StTrcd;
          end
        end
        StRd: begin
          cmd_q   <= (seg == PageW'(1)) ? CMD_BST : CMD_NOP;
          cnt_q   <= CntW'(1);
          state_q <= StData;
        end
        StData: begin
          cnt_q <= cnt_inc;
          if (cnt_q >= ClC && cnt_q < cl_seg) begin
            ack_q  <= 1'b1;
            data_q <= rd_data;
          end
          if (seg_done) begin
            cmd_q   <= CMD_PRE;
            addr_q  <= PreAllAddr;
            cnt_q   <= '0;
            state_q <= StPre;
          end else if (cnt_inc == seg_c) begin
            cmd_q <= CMD_BST;
          end else begin
            cmd_q <= CMD_NOP;
          end
        end
        StPre, StTrp: begin
          cmd_q <= CMD_NOP;
          if (cnt_inc == TrpC) begin
            // Address walker already advanced when PRE was issued.
            if (more) begin
              cmd_q   <= CMD_ACT;
              bank_q  <= gen_bank;
              addr_q  <= gen_row;
              cnt_q   <= '0;
              state_q <= StAct;
            end else begin
              busy_q  <= 1'b0;
              end_q   <= 1'b1;
              state_q <= StEnd;
            end
          end else begin
            cnt_q   <= cnt_inc;
            state_q <= StTrp;
          end
        end
        StEnd: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_busy       = busy_q;
  assign rd_ack        = ack_q;
  assign rd_end        = end_q;
  assign rd_sdram_cmd  = cmd_q;
  assign rd_sdram_bank = bank_q;
  assign rd_sdram_addr = addr_q;
  assign rd_sdram_data = data_q;

endmodule

// File: tb/tb_sdram_burst_read.sv
// Directed bench for sdram_burst_read: table of requests with hand-computed command counts,
// latencies and addresses, plus sequences for init gating, back-to-back and mid-burst reset.
module tb_sdram_burst_read;
  import sdram_pkg::*;

  localparam int unsigned BW = 2;
  localparam int unsigned RW = 13;
  localparam int unsigned CW = 9;
  localparam int unsigned LW = 10;
  localparam int unsigned DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_end = 1'b0;
  logic              rd_en = 1'b0;
  logic [BW+RW+CW-1:0] rd_addr = '0;
  logic [LW-1:0]     rd_bst_len = '0;
  logic [DW-1:0]     rd_data;
  logic              rd_busy, rd_ack, rd_end;
  logic [3:0]        cmd;
  logic [BW-1:0]     bank;
  logic [RW-1:0]     addr;
  logic [DW-1:0]     rdata;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Each cycle carries a distinct DQ word, so a capture in the wrong cycle shows up as bad data.
  assign rd_data = 16'(cyc) ^ 16'hA5C3;

  sdram_burst_read dut (
    .rd_clk       (clk),
    .rd_rst       (rst),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_bst_len   (rd_bst_len),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .rd_ack       (rd_ack),
    .rd_end       (rd_end),
    .rd_sdram_cmd (cmd),
    .rd_sdram_bank(bank),
    .rd_sdram_addr(addr),
    .rd_sdram_data(rdata)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  bit mon_en = 1'b0;
  int act_t[$], act_bank[$], act_row[$], rd_t[$], rd_col[$], bst_t[$], pre_t[$];
  int ack_t[$], end_t[$];
  int busy_cyc;

  task automatic clear_mon();
    act_t.delete(); act_bank.delete(); act_row.delete();
    rd_t.delete(); rd_col.delete(); bst_t.delete(); pre_t.delete();
    ack_t.delete(); end_t.delete();
    busy_cyc = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd == CMD_ACT) begin
        act_t.push_back(cyc); act_bank.push_back(int'(bank)); act_row.push_back(int'(addr));
      end
      if (cmd == CMD_READ) begin
        rd_t.push_back(cyc); rd_col.push_back(int'(addr));
      end
      if (cmd == CMD_BST) bst_t.push_back(cyc);
      if (cmd == CMD_PRE) pre_t.push_back(cyc);
      if (rd_ack) begin
        ack_t.push_back(cyc);
        check("ack_data", rdata, 16'(cyc - 1) ^ 16'hA5C3);
      end
      if (rd_end) end_t.push_back(cyc);
      if (rd_busy) busy_cyc++;
    end
  end

  typedef struct {
    int bank; int row; int col; int len;
    int nseg; int fseg; int lat;
    int fb; int fr; int lb; int lr; int fc; int lc;
  } vec_t;

  vec_t vecs[8];

  function automatic string nm(input int i, input string s);
    return $sformatf("v%0d_%s", i, s);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, cmd, CMD_NOP);
    check({tag, "_bank"}, bank, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data"}, rdata, 0);
    check({tag, "_ack"}, rd_ack, 0);
    check({tag, "_end"}, rd_end, 0);
    check({tag, "_busy"}, rd_busy, 0);
  endtask

  task automatic wait_ends(input int n, input int limit);
    for (int i = 0; i < limit && end_t.size() < n; i++) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int a;
    clear_mon();
    @(posedge clk); #1;
    rd_addr    = {BW'(v.bank), RW'(v.row), CW'(v.col)};
    rd_bst_len = LW'(v.len);
    rd_en      = 1'b1;
    mon_en     = 1'b1;
    a          = cyc;
    @(posedge clk); #1;
    rd_en      = 1'b0;
    rd_addr    = '1;
    rd_bst_len = '1;
    wait_ends(1, 3000);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    check(nm(idx, "end_cnt"), end_t.size(), 1);
    check(nm(idx, "lat"), (end_t.size() > 0) ? end_t[0] - a : -1, v.lat);
    check(nm(idx, "n_act"), act_t.size(), v.nseg);
    check(nm(idx, "n_read"), rd_t.size(), v.nseg);
    check(nm(idx, "n_bst"), bst_t.size(), v.nseg);
    check(nm(idx, "n_pre"), pre_t.size(), v.nseg);
    check(nm(idx, "n_ack"), ack_t.size(), v.len);
    check(nm(idx, "busy_cyc"), busy_cyc, v.lat - 1);
    if (v.nseg > 0 && act_t.size() > 0 && rd_t.size() > 0 && bst_t.size() > 0 &&
        pre_t.size() > 0 && ack_t.size() > 0) begin
      check(nm(idx, "first_bank"), act_bank[0], v.fb);
      check(nm(idx, "first_row"), act_row[0], v.fr);
      check(nm(idx, "last_bank"), act_bank[act_bank.size()-1], v.lb);
      check(nm(idx, "last_row"), act_row[act_row.size()-1], v.lr);
      check(nm(idx, "first_col"), rd_col[0], v.fc);
      check(nm(idx, "last_col"), rd_col[rd_col.size()-1], v.lc);
      check(nm(idx, "act_first"), act_t[0] - a, 1);
      check(nm(idx, "trcd"), rd_t[0] - act_t[0], 2);
      check(nm(idx, "bst_ofs"), bst_t[0] - rd_t[0], v.fseg);
      check(nm(idx, "pre_ofs"), pre_t[0] - rd_t[0], 3 + v.fseg);
      check(nm(idx, "ack_ofs"), ack_t[0] - rd_t[0], 4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    int a;
    //          bank row  col  len  nseg fseg lat   fb fr    lb lr  fc   lc
    vecs[0] = '{0,   0,   0,   10,  1,   10,  18,   0, 0,    0, 0,  0,   0};
    vecs[1] = '{0,   0,   505, 10,  2,   7,   25,   0, 0,    0, 1,  505, 0};
    vecs[2] = '{1,   8191,511, 2,   2,   1,   17,   1, 8191, 2, 0,  511, 0};
    vecs[3] = '{3,   8191,511, 2,   2,   1,   17,   3, 8191, 0, 0,  511, 0};
    vecs[4] = '{2,   5,   100, 1,   1,   1,   9,    2, 5,    2, 5,  100, 100};
    vecs[5] = '{1,   3,   7,   0,   0,   0,   1,    0, 0,    0, 0,  0,   0};
    vecs[6] = '{0,   10,  300, 1023,3,   212, 1045, 0, 10,   0, 12, 300, 0};
    vecs[7] = '{2,   7,   511, 513, 2,   1,   528,  2, 7,    2, 8,  511, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // init_end low: request must be held off.
    clear_mon();
    @(posedge clk); #1;
    rd_addr    = '0;
    rd_bst_len = LW'(10);
    rd_en      = 1'b1;
    mon_en     = 1'b1;
    repeat (5) @(posedge clk);
    check("noinit_cmds", act_t.size() + rd_t.size() + pre_t.size() + bst_t.size(), 0);
    check("noinit_busy", busy_cyc, 0);
    #1;
    init_end = 1'b1;
    x        = cyc;
    @(posedge clk);
    @(negedge clk);
    check("init_act", cmd, CMD_ACT);
    check("init_busy", rd_busy, 1);
    rd_en = 1'b0;
    wait_ends(1, 200);
    check("init_lat", (end_t.size() > 0) ? end_t[0] - x : -1, 18);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    check("init_n_ack", ack_t.size(), 10);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // rd_en held high across rd_end: next request starts on the following IDLE cycle.
    clear_mon();
    @(posedge clk); #1;
    rd_addr    = {BW'(2), RW'(5), CW'(100)};
    rd_bst_len = LW'(1);
    rd_en      = 1'b1;
    mon_en     = 1'b1;
    a          = cyc;
    for (int i = 0; i < 100 && act_t.size() < 2; i++) @(posedge clk);
    #1;
    rd_en = 1'b0;
    wait_ends(2, 100);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    check("b2b_n_act", act_t.size(), 2);
    check("b2b_n_end", end_t.size(), 2);
    check("b2b_gap", (act_t.size() > 1 && end_t.size() > 0) ? act_t[1] - end_t[0] : -1, 2);
    check("b2b_end2", (end_t.size() > 1) ? end_t[1] - a : -1, 19);
    check("b2b_n_ack", ack_t.size(), 2);

    // Reset asserted during the data phase.
    clear_mon();
    @(posedge clk); #1;
    rd_addr    = {BW'(1), RW'(5), CW'(3)};
    rd_bst_len = LW'(10);
    rd_en      = 1'b1;
    mon_en     = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    for (int i = 0; i < 100 && ack_t.size() < 2; i++) @(posedge clk);
    check("rst_pre_acks", ack_t.size(), 2);
    @(negedge clk); #2;
    mon_en   = 1'b0;
    rst      = 1'b1;
    init_end = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_hold_cmd", cmd, CMD_NOP);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    init_end = 1'b1;
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
